// File: rtl/ife_result_collector_if.sv
// Bundles the dispatch, writeback, done and commit signals of the IFE result
// collector. Signal names match the collector's external interface.
//   master : execution-core / IFE side (drives dispatch, writebacks, done)
//   slave  : the collector (drives snapshots, commit/timeout strobes, busy)
interface ife_result_collector_if #(
  parameter int unsigned BLOCK_ID_WIDTH = 8,
  parameter int unsigned NUM_CORES      = 2,
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned REG_WIDTH      = 64
);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  logic [NUM_CORES-1:0]                 dispatch_valid;
  logic [BLOCK_ID_WIDTH-1:0]            dispatch_block_id;
  logic [NUM_CORES-1:0]                 core_wb_valid;
  logic [NUM_CORES-1:0][IDX_W-1:0]      core_wb_idx;
  logic [NUM_CORES-1:0][REG_WIDTH-1:0]  core_wb_data;
  logic [NUM_CORES-1:0]                 core_done;
  logic [REG_WIDTH-1:0]                 core_result_0 [NUM_REGS];
  logic [REG_WIDTH-1:0]                 core_result_1 [NUM_REGS];
  logic                                 commit_valid_out;
  logic [BLOCK_ID_WIDTH-1:0]            commit_block_id;
  logic                                 timeout_out;
  logic                                 dispatch_drop;
  logic                                 busy;

  modport master (
    output dispatch_valid, dispatch_block_id, core_wb_valid, core_wb_idx,
           core_wb_data, core_done,
    input  core_result_0, core_result_1, commit_valid_out, commit_block_id,
           timeout_out, dispatch_drop, busy
  );

  modport slave (
    input  dispatch_valid, dispatch_block_id, core_wb_valid, core_wb_idx,
           core_wb_data, core_done,
    output core_result_0, core_result_1, commit_valid_out, commit_block_id,
           timeout_out, dispatch_drop, busy
  );
endinterface

// File: rtl/ife_result_collector.sv
// IFE result collector. Latches a parallel dispatch (mask + block id), captures
// per-core register writebacks into two snapshots, and raises a one-cycle
// commit strobe once every dispatched core is done, or a one-cycle timeout
// strobe if the cores fail to finish within TIMEOUT_CYCLES collect cycles.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - slave side of ife_result_collector_if (dispatch, writebacks,
//          done pulses in; snapshots, commit/timeout/drop strobes, busy out)
// All outputs are registered.
module ife_result_collector #(
  parameter int unsigned BLOCK_ID_WIDTH = 8,
  parameter int unsigned NUM_CORES      = 2,
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned REG_WIDTH      = 64,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                   clk,
  input logic                   rst,
  ife_result_collector_if.slave bus
);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_COMMIT,
    S_TIMEOUT
  } state_t;

  state_t                    state_q;
  logic [NUM_CORES-1:0]      mask_q;
  logic [NUM_CORES-1:0]      done_q;
  logic [NUM_CORES-1:0]      done_d;
  logic                      complete;
  logic [TMR_W-1:0]          timer_q;
  logic [BLOCK_ID_WIDTH-1:0] id_q;
  logic [REG_WIDTH-1:0]      res0_q [NUM_REGS];
  logic [REG_WIDTH-1:0]      res1_q [NUM_REGS];
  logic                      commit_q;
  logic                      timeout_q;
  logic                      drop_q;
  logic                      busy_q;

  // Done pulses arriving this cycle count toward completion immediately, so
  // the final done and the commit decision happen on the same edge.
  always_comb begin
    done_d   = done_q | (bus.core_done & mask_q);
    complete = (done_d == mask_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      done_q    <= '0;
      timer_q   <= '0;
      id_q      <= '0;
      commit_q  <= 1'b0;
      timeout_q <= 1'b0;
      drop_q    <= 1'b0;
      busy_q    <= 1'b0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        res0_q[r] <= '0;
        res1_q[r] <= '0;
      end
    end else begin
      commit_q  <= 1'b0;
      timeout_q <= 1'b0;
      drop_q    <= (state_q != S_IDLE) && (|bus.dispatch_valid);
      case (state_q)
        S_IDLE: begin
          if (|bus.dispatch_valid) begin
            mask_q  <= bus.dispatch_valid;
            id_q    <= bus.dispatch_block_id;
            done_q  <= '0;
            timer_q <= '0;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
              res0_q[r] <= '0;
              res1_q[r] <= '0;
            end
            state_q <= S_COLLECT;
            busy_q  <= 1'b1;
          end
        end
        S_COLLECT: begin
          timer_q <= timer_q + 1'b1;
          done_q  <= done_d;
          // x0 is hardwired to zero, so index 0 writes are discarded.
          if (mask_q[0] && bus.core_wb_valid[0] && (bus.core_wb_idx[0] != '0))
            res0_q[bus.core_wb_idx[0]] <= bus.core_wb_data[0];
          if (mask_q[1] && bus.core_wb_valid[1] && (bus.core_wb_idx[1] != '0))
            res1_q[bus.core_wb_idx[1]] <= bus.core_wb_data[1];
          // Completion on the last timer cycle takes priority over abort.
          if (complete) begin
            state_q  <= S_COMMIT;
            commit_q <= 1'b1;
          end else if (timer_q == TMR_LAST) begin
            state_q   <= S_TIMEOUT;
            timeout_q <= 1'b1;
          end
        end
        S_COMMIT, S_TIMEOUT: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.core_result_0    = res0_q;
  assign bus.core_result_1    = res1_q;
  assign bus.commit_valid_out = commit_q;
  assign bus.commit_block_id  = id_q;
  assign bus.timeout_out      = timeout_q;
  assign bus.dispatch_drop    = drop_q;
  assign bus.busy             = busy_q;
endmodule
